// File: rtl/hazard_unit.sv
// Pipeline hazard control: stall/flush decisions for a 5-stage pipeline,
// a small RUN/DWAIT/HALTED FSM and performance counters.
package hazard_pkg;
    typedef enum logic [1:0] {
        NO_STALL   = 2'd0,
        IFID_STALL = 2'd1,
        IDEX_STALL = 2'd2,
        FULL_STALL = 2'd3
    } pipe_stall_t;
endpackage

module hazard_unit
    import hazard_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic        exmem_dREN,
    input  logic        exmem_dWEN,
    input  logic        idex_dREN,
    input  logic [4:0]  idex_rd,
    input  logic [4:0]  ifid_rs,
    input  logic [4:0]  ifid_rt,
    input  logic        ifid_uses_rt,
    input  logic        idex_branch_taken,
    input  logic        ifid_jump,
    input  logic        memwb_halt,
    output pipe_stall_t pipe_stall,
    output logic        ifid_FLUSH,
    output logic        idex_FLUSH,
    output logic        exmem_FLUSH,
    output logic        memwb_FLUSH,
    output logic        pc_wen,
    output logic        halt,
    output logic [31:0] stall_cycles,
    output logic [15:0] flush_count,
    output logic [15:0] dmiss_count
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state_r;
    state_t      next_state_s;
    pipe_stall_t pipe_stall_s;
    logic        pc_wen_s;
    logic        ifid_flush_s;
    logic        idex_flush_s;
    logic        dmem_busy_s;
    logic        load_use_s;
    logic        halt_r;
    logic [31:0] stall_cycles_r;
    logic [15:0] flush_count_r;
    logic [15:0] dmiss_count_r;

    assign dmem_busy_s = (exmem_dREN | exmem_dWEN) & ~dhit;
    assign load_use_s  = idex_dREN & (idex_rd != 5'd0) &
                         ((idex_rd == ifid_rs) | (ifid_uses_rt & (idex_rd == ifid_rt)));

    // Priority decode of stall/flush controls and next state; reset forces a full stall.
    always_comb begin
        pipe_stall_s = FULL_STALL;
        pc_wen_s     = 1'b0;
        ifid_flush_s = 1'b0;
        idex_flush_s = 1'b0;
        next_state_s = state_r;
        if (!nRST) begin
            next_state_s = RUN;
        end else if (state_r == HALTED) begin
            next_state_s = HALTED;
        end else if (memwb_halt) begin
            next_state_s = HALTED;
        end else if (dmem_busy_s) begin
            next_state_s = DWAIT;
        end else begin
            next_state_s = RUN;
            if (idex_branch_taken) begin
                pipe_stall_s = NO_STALL;
                pc_wen_s     = 1'b1;
                ifid_flush_s = 1'b1;
                idex_flush_s = 1'b1;
            end else if (load_use_s) begin
                pipe_stall_s = IDEX_STALL;
            end else if (!ihit) begin
                pipe_stall_s = IFID_STALL;
            end else begin
                pipe_stall_s = NO_STALL;
                pc_wen_s     = 1'b1;
                ifid_flush_s = ifid_jump;
            end
        end
    end

    // State, sticky halt flag and performance counters.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r        <= RUN;
            halt_r         <= 1'b0;
            stall_cycles_r <= 32'd0;
            flush_count_r  <= 16'd0;
            dmiss_count_r  <= 16'd0;
        end else begin
            state_r <= next_state_s;
            halt_r  <= (next_state_s == HALTED);
            if ((pipe_stall_s != NO_STALL) && (state_r != HALTED)) begin
                stall_cycles_r <= stall_cycles_r + 32'd1;
            end
            if ((ifid_flush_s | idex_flush_s) && (flush_count_r != 16'hFFFF)) begin
                flush_count_r <= flush_count_r + 16'd1;
            end
            // Only a fresh miss out of RUN counts; lingering in DWAIT does not.
            if ((state_r == RUN) && (next_state_s == DWAIT) && (dmiss_count_r != 16'hFFFF)) begin
                dmiss_count_r <= dmiss_count_r + 16'd1;
            end
        end
    end

    assign pipe_stall   = pipe_stall_s;
    assign pc_wen       = pc_wen_s;
    assign ifid_FLUSH   = ifid_flush_s;
    assign idex_FLUSH   = idex_flush_s;
    assign exmem_FLUSH  = 1'b0;
    assign memwb_FLUSH  = 1'b0;
    assign halt         = halt_r;
    assign stall_cycles = stall_cycles_r;
    assign flush_count  = flush_count_r;
    assign dmiss_count  = dmiss_count_r;

endmodule
